// File: rtl/lp_rx_packet_buffer.sv
// Receive-side packet buffer: stores link packets in RAM, commits only CRC-good
// complete packets and replays them on a valid/ready stream with start/end marks.
module lp_rx_packet_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int STOP_LEVEL = 72
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] data_rec,
  input  logic        data_rec_start,
  input  logic        data_rec_end,
  input  logic        crc_error_rec,
  output logic        data_rec_stop,
  output logic [15:0] out_data,
  output logic        out_start,
  output logic        out_end,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } wr_state_t;

  wr_state_t state, state_nxt;

  logic [PW-1:0]         wr_ptr, wr_nxt;
  logic [PW-1:0]         commit_ptr, commit_nxt;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         used, free, free_base, base, room;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic                  wr_en;
  logic                  ok_inc;
  logic [1:0]            drop_inc;
  logic                  stop_nxt;
  logic                  fetch;
  logic                  after_end;

  logic [16:0] mem [DEPTH];

  assign used      = wr_ptr - rd_ptr;
  assign free      = DEPTH_P - used;
  // A new start always lands at commit_ptr, so its room ignores any abandoned words.
  assign free_base = DEPTH_P - (commit_ptr - rd_ptr);
  assign base      = data_rec_start ? commit_ptr : wr_ptr;
  assign room      = data_rec_start ? free_base : free;
  assign stop_nxt  = 32'(free) < 32'(STOP_LEVEL);

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    wr_en      = 1'b0;
    wr_addr    = base[DEPTH_LOG2-1:0];
    ok_inc     = 1'b0;
    drop_inc   = 2'd0;
    if (data_rec_start && state == RECV) begin
      drop_inc = drop_inc + 2'd1;
    end
    if (data_rec_start || state == RECV) begin
      if (room == '0) begin
        wr_nxt    = commit_ptr;
        drop_inc  = drop_inc + 2'd1;
        state_nxt = data_rec_end ? IDLE : DROP;
      end else begin
        wr_en = 1'b1;
        if (data_rec_end) begin
          state_nxt = IDLE;
          if (!crc_error_rec) begin
            commit_nxt = base + 1'b1;
            wr_nxt     = base + 1'b1;
            ok_inc     = 1'b1;
          end else begin
            wr_nxt   = commit_ptr;
            drop_inc = drop_inc + 2'd1;
          end
        end else begin
          wr_nxt    = base + 1'b1;
          state_nxt = RECV;
        end
      end
    end else if (state == DROP && data_rec_end) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      pkt_ok_cnt    <= '0;
      pkt_drop_cnt  <= '0;
      data_rec_stop <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_nxt;
      commit_ptr    <= commit_nxt;
      pkt_ok_cnt    <= pkt_ok_cnt + 16'(ok_inc);
      pkt_drop_cnt  <= pkt_drop_cnt + 16'(drop_inc);
      data_rec_stop <= stop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {data_rec_end, data_rec};
    end
  end

  // The output register doubles as the RAM read register, giving end+2 latency.
  assign fetch = (rd_ptr != commit_ptr) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (res) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
      out_data  <= '0;
      after_end <= 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        after_end <= out_end;
      end
      if (fetch) begin
        rd_ptr              <= rd_ptr + 1'b1;
        {out_end, out_data} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        out_start           <= out_valid ? out_end : after_end;
        out_valid           <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
